// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word width, requester indices and the
// byte-to-word address helper used by the data-memory arbiter.
package cpu_pkg;

  localparam int WORD_W  = 32;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;
  localparam int WAIT_W  = 4;
  localparam int CNT_W   = 16;

  // Drops the byte offset; callers keep only the low RAM-address bits, so
  // anything above the RAM depth simply wraps.
  function automatic logic [WORD_W-1:0] byte_to_word(input logic [WORD_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational picker: CPU priority with a starvation override,
// or round-robin against the previously granted requester.
module arb_pick2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_mode,
  input  logic       last,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt[REQ_CPU] = 1'b1;
      2'b10: gnt[REQ_DBG] = 1'b1;
      2'b11: begin
        // last == 1 means the debug port won the previous granted cycle.
        if (rr_mode) begin
          if (last) gnt[REQ_CPU] = 1'b1;
          else      gnt[REQ_DBG] = 1'b1;
        end else begin
          if (starve) gnt[REQ_DBG] = 1'b1;
          else        gnt[REQ_CPU] = 1'b1;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store port (m0) and
// the debug/loader port (m1); one access per cycle, 1-cycle read return.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_AW   = 8,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [WORD_W-1:0] m0_addr,
  input  logic [WORD_W-1:0] m1_addr,
  input  logic [WORD_W-1:0] m0_wdata,
  input  logic [WORD_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [WORD_W-1:0] m0_rdata,
  output logic [WORD_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [1:0]        rd_owner;
  logic              last;
  logic              starve;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WORD_W-1:0] word0;
  logic [WORD_W-1:0] word1;
  logic              unused_word_bits;

  assign req    = {m1_req, m0_req};
  assign starve = (wait_cnt == WAIT_W'(MAX_WAIT));

  arb_pick2 u_pick (
    .req     (req),
    .rr_mode (RR_MODE != 0),
    .last    (last),
    .starve  (starve),
    .gnt     (gnt)
  );

  assign m0_gnt = gnt[REQ_CPU];
  assign m1_gnt = gnt[REQ_DBG];

  assign word0            = byte_to_word(m0_addr);
  assign word1            = byte_to_word(m1_addr);
  assign unused_word_bits = ^{word0[WORD_W-1:MEM_AW], word1[WORD_W-1:MEM_AW]};

  // RAM port follows the winner; write enable is gated so an idle cycle
  // can never write.
  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = word0[MEM_AW-1:0];
    mem_wdata = m0_wdata;
    if (gnt[REQ_DBG]) begin
      mem_we    = m1_we;
      mem_addr  = word1[MEM_AW-1:0];
      mem_wdata = m1_wdata;
    end else if (gnt[REQ_CPU]) begin
      mem_we    = m0_we;
    end
  end

  // Grant cycle -> return cycle: arbitration history and read ownership.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= '0;
      last         <= 1'b1;
      rd_owner     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (!m1_req || gnt[REQ_DBG])
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;

      if (|gnt)
        last <= gnt[REQ_DBG];

      rd_owner <= gnt & {2{~mem_we}};

      if (&req && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign m0_rvalid = rd_owner[REQ_CPU];
  assign m1_rvalid = rd_owner[REQ_DBG];
  assign m0_rdata  = rd_owner[REQ_CPU] ? mem_rdata : '0;
  assign m1_rdata  = rd_owner[REQ_DBG] ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one priority-mode and one round-robin
// instance share stimulus, each with its own behavioural RAM.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic        m0_gnt [2];
  logic        m1_gnt [2];
  logic        m0_rvalid [2];
  logic        m1_rvalid [2];
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [15:0] conflict_cnt [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] q00[$], q01[$], q10[$], q11[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] ram [256];
    logic [31:0] rdq;

    dmem_arbiter #(.MEM_AW(8), .RR_MODE(g), .MAX_WAIT(4)) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .m0_req       (m0_req),
      .m1_req       (m1_req),
      .m0_we        (m0_we),
      .m1_we        (m1_we),
      .m0_addr      (m0_addr),
      .m1_addr      (m1_addr),
      .m0_wdata     (m0_wdata),
      .m1_wdata     (m1_wdata),
      .m0_gnt       (m0_gnt[g]),
      .m1_gnt       (m1_gnt[g]),
      .m0_rvalid    (m0_rvalid[g]),
      .m1_rvalid    (m1_rvalid[g]),
      .m0_rdata     (m0_rdata[g]),
      .m1_rdata     (m1_rdata[g]),
      .mem_en       (mem_en[g]),
      .mem_we       (mem_we[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (rdq),
      .conflict_cnt (conflict_cnt[g])
    );

    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
        else           rdq <= ram[mem_addr[g]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input int p, input logic [31:0] v);
    case ({d[0], p[0]})
      2'b00:   q00.push_back(v);
      2'b01:   q01.push_back(v);
      2'b10:   q10.push_back(v);
      default: q11.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int d, input int p, output bit ok, output logic [31:0] v);
    ok = 1'b0;
    v  = '0;
    case ({d[0], p[0]})
      2'b00:   if (q00.size() > 0) begin ok = 1'b1; v = q00.pop_front(); end
      2'b01:   if (q01.size() > 0) begin ok = 1'b1; v = q01.pop_front(); end
      2'b10:   if (q10.size() > 0) begin ok = 1'b1; v = q10.pop_front(); end
      default: if (q11.size() > 0) begin ok = 1'b1; v = q11.pop_front(); end
    endcase
  endtask

  task automatic mon(input int d, input int p, input logic rv, input logic [31:0] rd);
    bit          ok;
    logic [31:0] e;
    if (rv === 1'b1) begin
      pop_exp(d, p, ok, e);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rvalid_unexpected d%0d m%0d actual rdata=%h required no response", d, p, rd);
      end else if (rd !== e) begin
        errors++;
        $display("FAIL rdata d%0d m%0d actual=%h required=%h", d, p, rd, e);
      end
    end else begin
      chk($sformatf("rdata_idle_d%0d_m%0d", d, p), rd, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon(d, 0, m0_rvalid[d], m0_rdata[d]);
      mon(d, 1, m1_rvalid[d], m1_rdata[d]);
    end
  end

  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string tag, input int d, input logic e0, input logic e1);
    chk($sformatf("%s_m0gnt_d%0d", tag, d), {31'b0, m0_gnt[d]}, {31'b0, e0});
    chk($sformatf("%s_m1gnt_d%0d", tag, d), {31'b0, m1_gnt[d]}, {31'b0, e1});
    chk($sformatf("%s_memen_d%0d", tag, d), {31'b0, mem_en[d]}, {31'b0, e0 | e1});
  endtask

  initial begin
    bit p1, r1g;
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_m0rvalid_d%0d", d), {31'b0, m0_rvalid[d]}, 32'h0);
      chk($sformatf("rst_m1rvalid_d%0d", d), {31'b0, m1_rvalid[d]}, 32'h0);
      chk($sformatf("rst_conflict_d%0d", d), {16'b0, conflict_cnt[d]}, 32'h0);
    end
    rst_n = 1'b1;

    // m0 write then read of 0x10
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk_gnt("wr10", d, 1, 0);
      chk($sformatf("wr10_addr_d%0d", d), {24'b0, mem_addr[d]}, 32'h4);
      chk($sformatf("wr10_we_d%0d", d), {31'b0, mem_we[d]}, 32'h1);
      chk($sformatf("wr10_wdata_d%0d", d), mem_wdata[d], 32'hDEADBEEF);
    end
    cyc(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk_gnt("rd10", d, 1, 0);
      chk($sformatf("rd10_addr_d%0d", d), {24'b0, mem_addr[d]}, 32'h4);
      chk($sformatf("rd10_we_d%0d", d), {31'b0, mem_we[d]}, 32'h0);
      push_exp(d, 0, 32'hDEADBEEF);
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // m1 write to 0x404 wraps to word 1; m0 reads it back via 0x4
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0404, 32'h12345678);
    for (int d = 0; d < 2; d++) begin
      chk_gnt("wr404", d, 0, 1);
      chk($sformatf("wr404_addr_d%0d", d), {24'b0, mem_addr[d]}, 32'h1);
      chk($sformatf("wr404_wdata_d%0d", d), mem_wdata[d], 32'h12345678);
    end
    cyc(1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk_gnt("rd4", d, 1, 0);
      chk($sformatf("rd4_addr_d%0d", d), {24'b0, mem_addr[d]}, 32'h1);
      push_exp(d, 0, 32'h12345678);
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Contention, both reading; last grant was m0, so round-robin opens with m1
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 32'h10, 32'h0, 1, 0, 32'h404, 32'h0);
      p1  = ((i % 5) == 4);
      r1g = ((i % 2) == 0);
      chk_gnt($sformatf("conA%0d", i), 0, !p1, p1);
      chk_gnt($sformatf("conA%0d", i), 1, !r1g, r1g);
      for (int d = 0; d < 2; d++)
        chk($sformatf("conA%0d_cnt_d%0d", i, d), {16'b0, conflict_cnt[d]}, 32'(i));
      if (p1)  push_exp(0, 1, 32'h12345678); else push_exp(0, 0, 32'hDEADBEEF);
      if (r1g) push_exp(1, 1, 32'h12345678); else push_exp(1, 0, 32'hDEADBEEF);
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++)
      chk($sformatf("conA_total_d%0d", d), {16'b0, conflict_cnt[d]}, 32'd10);
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Reset lands before the read return edge: no rvalid, state cleared
    cyc(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) chk_gnt("rdrst", d, 1, 0);
    rst_n = 1'b0;
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_mid_rvalid_d%0d", d), {31'b0, m0_rvalid[d]}, 32'h0);
      chk($sformatf("rst_mid_cnt_d%0d", d), {16'b0, conflict_cnt[d]}, 32'h0);
    end
    rst_n = 1'b1;

    // After reset: round-robin opens with m0, priority starves m1 for 4 cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h10, 32'h0, 1, 0, 32'h404, 32'h0);
      p1  = (i == 4);
      r1g = ((i % 2) == 1);
      chk_gnt($sformatf("conB%0d", i), 0, !p1, p1);
      chk_gnt($sformatf("conB%0d", i), 1, !r1g, r1g);
      for (int d = 0; d < 2; d++)
        chk($sformatf("conB%0d_cnt_d%0d", i, d), {16'b0, conflict_cnt[d]}, 32'(i));
      if (p1)  push_exp(0, 1, 32'h12345678); else push_exp(0, 0, 32'hDEADBEEF);
      if (r1g) push_exp(1, 1, 32'h12345678); else push_exp(1, 0, 32'hDEADBEEF);
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++)
      chk($sformatf("conB_total_d%0d", d), {16'b0, conflict_cnt[d]}, 32'd5);

    // Long conflicting writes drive conflict_cnt into saturation
    for (int i = 0; i < 65540; i++)
      cyc(1, 1, 32'h20, 32'h0, 1, 1, 32'h24, 32'h0);
    for (int d = 0; d < 2; d++)
      chk($sformatf("sat_d%0d", d), {16'b0, conflict_cnt[d]}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h20, 32'h0, 1, 1, 32'h24, 32'h0);
    for (int d = 0; d < 2; d++)
      chk($sformatf("sat_hold_d%0d", d), {16'b0, conflict_cnt[d]}, 32'h0000FFFF);

    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("sb_left_d0_m0", 32'(q00.size()), 32'h0);
    chk("sb_left_d0_m1", 32'(q01.size()), 32'h0);
    chk("sb_left_d1_m0", 32'(q10.size()), 32'h0);
    chk("sb_left_d1_m1", 32'(q11.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the CPU's single-port data memory between two requesters:
  - m0: the CPU load/store port.
  - m1: a debug/loader port that preloads matrix operands and reads back results.
- Serves one access per cycle. Read data returns to the requester after a fixed 1-cycle latency.
- Contention is resolved by a starvation-guarded CPU-priority policy or by round-robin, selected by a parameter.
- Sits between the CPU datapath's memory stage and the data-memory RAM instance.

## Interface
- `MEM_AW`, default 8: RAM word-address width (RAM depth = 2^MEM_AW words).
- `RR_MODE`, default 0: 0 = m0 priority with starvation guard; 1 = strict round-robin.
- `MAX_WAIT`, default 4: cycles m1 may be refused while requesting before a forced grant (`RR_MODE`=0 only; legal range 1..15).
- `clk`  in  1: system clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1: access request; held with addr/we/wdata stable until granted.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32: byte address. Bits [MEM_AW+1:2] are used; all other bits are ignored, so addresses wrap.
- `m0_wdata`, `m1_wdata`  in  32: write data.
- `m0_gnt`, `m1_gnt`  out  1: combinational accept in the current cycle.
- `m0_rvalid`, `m1_rvalid`  out  1: read data valid, registered.
- `m0_rdata`, `m1_rdata`  out  32: read data, driven from `mem_rdata` while the matching rvalid is high, else 0.
- `mem_en`  out  1: RAM access strobe.
- `mem_we`  out  1: RAM write enable.
- `mem_addr`  out  MEM_AW: RAM word address.
- `mem_wdata`  out  32: RAM write data.
- `mem_rdata`  in  32: RAM read data, valid the cycle after `mem_en`&!`mem_we`.
- `conflict_cnt`  out  16: count of cycles with both req high, saturating at 0xFFFF.

## Operation
- Each cycle at most one winner.
  - `mem_en` = winner exists.
  - `mem_*` are driven combinationally from the winner's inputs.
  - `mX_gnt` = 1 for the winner only.
- Grant rules, `RR_MODE`=0:
  - Only one req high: that requester wins.
  - Both high: m0 wins unless `wait_cnt` == `MAX_WAIT`; then m1 wins.
  - `wait_cnt` (4 bit) increments on every cycle m1_req=1 and m1_gnt=0.
  - `wait_cnt` clears on m1_gnt or when m1_req=0.
- Grant rules, `RR_MODE`=1:
  - Single requester wins.
  - On conflict the requester not granted last wins.
  - The `last` register updates only on cycles with a grant.
- Read return:
  - Registered `rd_owner` (2 bit one-hot) is set for a granted read and cleared otherwise.
  - Next cycle: `mX_rvalid` = `rd_owner`[X] and `mX_rdata` = `mem_rdata`.
- Writes produce no response beyond gnt.
- `conflict_cnt` increments on each cycle with m0_req & m1_req, saturating.
- Reset values:
  - `wait_cnt` = 0.
  - `last` = m1, so m0 wins the first round-robin conflict.
  - `rd_owner` = 0, so both rvalid = 0 and both rdata = 0.
  - `conflict_cnt` = 0.
- Combinational outputs at reset follow their inputs.
- Reset asserted mid-read clears `rd_owner`; the in-flight read's rvalid is suppressed.
- Requester deasserting req before gnt: permitted, no side effect beyond clearing `wait_cnt` (m1).

## Timing
- Grant latency is 0 cycles when uncontended.
- Read latency: rvalid one cycle after the gnt cycle.
- Back-to-back grants to the same or different requesters every cycle, with no bubbles.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first or sequential access; the arbiter adds no forwarding).
- Worst-case m1 wait in `RR_MODE`=0 is `MAX_WAIT` cycles.
- Worst-case wait for either requester in `RR_MODE`=1 is 1 cycle.
- The combinational path req→gnt→CPU stall must close timing with the CPU's mem stage. m0_gnt=0 is the CPU's memory stall.

## Structure
- Shared package `cpu_pkg`: word width (32), requester index constants `REQ_CPU`=0 and `REQ_DBG`=1, and the byte-to-word address slice function.
- One natural sub-module, `arb_pick2`: a combinational two-way picker taking both req lines, mode, the `last` register and the starve flag, returning a one-hot grant.
- Counters and `rd_owner` stay in `dmem_arbiter`.

## Test plan
- m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 → m0_gnt both cycles; m0_rvalid=1 with rdata 0xDEADBEEF on the cycle after the read gnt; `mem_addr`=4 on both accesses.
- `RR_MODE`=0, `MAX_WAIT`=4, both req held high with reads → m0 granted 4 cycles, m1 granted on the 5th, pattern repeats; `conflict_cnt` increments every cycle.
- `RR_MODE`=1, both req held high → grants alternate m0,m1,m0,…; each rvalid lands only on its owner one cycle after its grant.
- m1 writes 0x12345678 to addr 0x0000_0404 with `MEM_AW`=8 → `mem_addr`=0x01 (wrap); m0 reading 0x4 gets 0x12345678.
- Assert reset (low) the cycle after an m0 read gnt → m0_rvalid stays 0; after release `wait_cnt`=0, `conflict_cnt`=0, and the first round-robin conflict grants m0.
- Hold both req for 70000 cycles → `conflict_cnt` saturates at 0xFFFF and does not wrap.
